xalu_ise_issue: RTL and testbench

Upstream issue stage for the custom-ALU ISE datapath on the RV64 core. It accepts one custom instruction at a time from the core pipeline and registers its operands. It drives the ISE ALU (fn/imm/in1/in2/val), waits a bounded number of cycles for the ALU's output-valid, and returns the result, or an illegal-instruction flag, through a valid/ready response channel with backpressure.

---
 rtl/xalu_ise_issue.sv | 147 ++++++++++++++
 tb/tb_xalu_ise_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xalu_ise_issue.sv
// xalu_ise_issue -- issue stage between the RV64 core pipeline and the
// custom-ALU ISE datapath.
//
// Takes one custom instruction at a time and registers its operands. It then
// presents them to the ISE ALU and waits up to TIMEOUT cycles for x_oval.
// The result, or an illegal-instruction flag, is returned on a valid/ready
// response channel.
//
// Optional feature: define XALU_ISE_ISSUE_BYPASS_EN to accept a new request
// in the same cycle the pending response retires (2-cycle back-to-back issue).
//
// Ports:
//   ise_clk, ise_rst     clock (rising edge), async active-low reset
//   kill                 synchronous flush, highest priority
//   req_*                instruction request channel (valid/ready)
//   x_val/fn/imm/in1/in2 request to the ISE ALU
//   x_oval, x_out        ISE ALU result (x_oval combinational from x_val)
//   rsp_*                response channel (valid/ready) with rd tag and
//                        illegal flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no instruction held; ready for a request
// ISSUE | operands driven to the ISE ALU, waiting for x_oval or timeout
// RESP  | response held on rsp_* until rsp_ready
module xalu_ise_issue #(
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned XLEN    = 64
) (
    input  logic            ise_clk,
    input  logic            ise_rst,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_fn,
    input  logic [6:0]      req_imm,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    output logic            x_val,
    output logic [4:0]      x_fn,
    output logic [6:0]      x_imm,
    output logic [XLEN-1:0] x_in1,
    output logic [XLEN-1:0] x_in2,
    input  logic            x_oval,
    input  logic [XLEN-1:0] x_out,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [4:0] rd_q;
    logic       accept;
    logic       issue_done;

    assign accept     = req_valid && req_ready;
    // x_oval takes priority over the timeout on the last allowed cycle.
    assign issue_done = x_oval || (cnt_q == TMO_LAST);

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = ISSUE;
                ISSUE:   if (issue_done) state_d = RESP;
                RESP:    if (rsp_ready) state_d = accept ? ISSUE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        x_val     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE:  req_ready = !kill;
            ISSUE: x_val     = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
`ifdef XALU_ISE_ISSUE_BYPASS_EN
                req_ready = rsp_ready && !kill;
`else
                req_ready = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Operand, counter and response registers. The response fields only load
    // when ISSUE completes, so they stay stable throughout RESP even if a
    // bypassed request reloads the operand registers.
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            x_fn        <= '0;
            x_imm       <= '0;
            x_in1       <= '0;
            x_in2       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            rsp_data    <= '0;
            rsp_rd      <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            if (accept) begin
                x_fn  <= req_fn;
                x_imm <= req_imm;
                x_in1 <= req_rs1;
                x_in2 <= req_rs2;
                rd_q  <= req_rd;
                cnt_q <= '0;
            end else if (state_q == ISSUE && !kill && !issue_done && cnt_q < TMO_LAST) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (state_q == ISSUE && !kill && issue_done) begin
                rsp_data    <= x_oval ? x_out : '0;
                rsp_illegal <= !x_oval;
                rsp_rd      <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Testbench for xalu_ise_issue: randomized transactions plus directed cases.
// A transaction-level reference model predicts each response. The bench
// contains a simple ISE ALU that claims opcodes with fn[1:0] != 0 after a
// programmable latency.
module tb_xalu_ise_issue;

    localparam int TIMEOUT = 4;
    localparam int XLEN    = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            kill = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [4:0]      req_fn = '0;
    logic [6:0]      req_imm = '0;
    logic [XLEN-1:0] req_rs1 = '0;
    logic [XLEN-1:0] req_rs2 = '0;
    logic [4:0]      req_rd = '0;
    logic            x_val;
    logic [4:0]      x_fn;
    logic [6:0]      x_imm;
    logic [XLEN-1:0] x_in1;
    logic [XLEN-1:0] x_in2;
    logic            x_oval;
    logic [XLEN-1:0] x_out;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_illegal;

    int n_checks = 0;
    int n_errors = 0;

    // Behaviour of the bench ALU.
    int              alu_lat = 0;
    int              alu_cnt = 0;
    logic            use_fixed = 1'b0;
    logic [XLEN-1:0] fixed_val = '0;

    xalu_ise_issue #(.TIMEOUT(TIMEOUT), .XLEN(XLEN)) dut (
        .ise_clk    (clk),
        .ise_rst    (rst_n),
        .kill       (kill),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fn     (req_fn),
        .req_imm    (req_imm),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .x_val      (x_val),
        .x_fn       (x_fn),
        .x_imm      (x_imm),
        .x_in1      (x_in1),
        .x_in2      (x_in2),
        .x_oval     (x_oval),
        .x_out      (x_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_rd     (rsp_rd),
        .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] alu_func(logic [4:0] fn, logic [6:0] imm,
                                                 logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        if (use_fixed) return fixed_val;
        return (a - b) ^ {52'd0, imm, fn};
    endfunction

    always @(posedge clk) alu_cnt <= x_val ? alu_cnt + 1 : 0;
    assign x_oval = x_val && (x_fn[1:0] != 2'b00) && (alu_cnt == alu_lat);
    assign x_out  = alu_func(x_fn, x_imm, x_in1, x_in2);

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and return at the negedge of its first ISSUE cycle.
    task automatic start_req(input logic [4:0] fn, input logic [6:0] imm,
                             input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                             input logic [4:0] rd, input int lat);
        int w;
        @(negedge clk);
        alu_lat = lat;
        req_fn = fn; req_imm = imm; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full transaction with reference-model prediction of content and timing.
    task automatic do_txn(input logic [4:0] fn, input logic [6:0] imm,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                          input logic [4:0] rd, input int lat, input int bp);
        int cyc, xv, exp_cyc;
        logic legal;
        logic [XLEN-1:0] exp_data;
        legal    = (fn[1:0] != 2'b00) && (lat <= TIMEOUT - 1);
        exp_data = legal ? alu_func(fn, imm, rs1, rs2) : '0;
        exp_cyc  = legal ? lat + 2 : TIMEOUT + 1;

        start_req(fn, imm, rs1, rs2, rd, lat);
        check("x_in1", x_in1, rs1);
        check("x_in2", x_in2, rs2);
        check("x_fn_imm", {x_fn, x_imm}, {fn, imm});
        check("req_ready_issue", req_ready, 0);
        cyc = 1;
        xv  = 0;
        while (!rsp_valid && cyc < 40) begin
            xv += int'(x_val);
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", cyc, exp_cyc);
        check("x_val_cycles", xv, exp_cyc - 1);
        for (int i = 0; i < bp; i++) begin
            check("rsp_hold_ctl", {rsp_valid, rsp_illegal, rsp_rd}, {1'b1, !legal, rd});
            check("rsp_hold_data", rsp_data, exp_data);
            check("req_ready_bp", req_ready, 0);
            @(negedge clk);
        end
        check("rsp_ctl", {rsp_valid, rsp_illegal, rsp_rd}, {1'b1, !legal, rd});
        check("rsp_data", rsp_data, exp_data);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_retired", rsp_valid, 0);
        check("idle_ready", {x_val, req_ready}, 2'b01);
    endtask

    initial begin
        int seen;
        // Reset state
        #12;
        check("rst_rsp", {rsp_valid, rsp_illegal, rsp_rd}, '0);
        check("rst_data", rsp_data, '0);
        check("rst_x", {x_val, x_fn, x_imm}, '0);
        check("rst_in1", x_in1, '0);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Supported op, immediate ALU response
        use_fixed = 1'b1;
        fixed_val = 64'hDEAD_BEEF;
        do_txn(5'b00001, 7'b1000011, 64'h1, 64'h2, 5'd5, 0, 0);
        use_fixed = 1'b0;

        // Unsupported op: runs to timeout
        do_txn(5'b00000, 7'h11, 64'h1234, 64'h5678, 5'd9, 0, 0);

        // Backpressure for 6 cycles
        do_txn(5'b00110, 7'h2A, 64'hFFFF_0000_1111_2222, 64'h3, 5'd30, 2, 6);

        // Latency right at the timeout edge, and one past it
        do_txn(5'b00011, 7'h01, 64'h99, 64'h11, 5'd1, TIMEOUT - 1, 1);
        do_txn(5'b00010, 7'h02, 64'h77, 64'h22, 5'd2, TIMEOUT, 0);

        // Kill on the second ISSUE cycle
        start_req(5'b00001, 7'h05, 64'hAB, 64'hCD, 5'd7, 10);
        @(negedge clk);
        kill = 1'b1;
        #1;
        check("kill_req_ready", req_ready, 0);
        @(negedge clk);
        check("kill_x_val", x_val, 0);
        check("kill_rsp_valid", rsp_valid, 0);
        kill = 1'b0;
        #1;
        check("kill_ready_after", req_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen += int'(rsp_valid) + int'(x_val);
        end
        check("kill_no_rsp", seen, 0);

        // kill together with req_valid in IDLE: nothing accepted
        @(negedge clk);
        kill = 1'b1;
        req_valid = 1'b1;
        #1;
        check("kill_blocks_accept", req_ready, 0);
        @(negedge clk);
        kill = 1'b0;
        req_valid = 1'b0;
        check("kill_no_issue", x_val, 0);

        // kill and rsp_ready together in RESP
        start_req(5'b00001, 7'h00, 64'h5, 64'h6, 5'd3, 0);
        @(negedge clk);
        check("resp_before_kill", rsp_valid, 1);
        kill = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        rsp_ready = 1'b0;
        check("kill_resp", {rsp_valid, x_val}, 2'b00);

        // Asynchronous reset while in RESP
        start_req(5'b00010, 7'h7F, 64'hCAFE_F00D_0000_0001, 64'h1, 5'd17, 1);
        @(negedge clk);
        @(negedge clk);
        check("resp_before_rst", {rsp_valid, rsp_rd}, {1'b1, 5'd17});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp", {rsp_valid, rsp_illegal, rsp_rd}, '0);
        check("arst_data", rsp_data, '0);
        check("arst_in1", x_in1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle", {x_val, rsp_valid, req_ready}, 3'b001);

`ifdef XALU_ISE_ISSUE_BYPASS_EN
        // Back-to-back with rsp_ready tied high
        @(negedge clk);
        alu_lat = 0;
        rsp_ready = 1'b1;
        req_fn = 5'b00001; req_imm = 7'h3; req_rs1 = 64'h40; req_rs2 = 64'h4; req_rd = 5'd11;
        req_valid = 1'b1;
        @(negedge clk);
        check("byp_issue1", x_val, 1);
        req_rs1 = 64'h900; req_rs2 = 64'h9; req_rd = 5'd12;
        @(negedge clk);
        check("byp_rsp1", {rsp_valid, rsp_illegal, rsp_rd, req_ready}, {1'b1, 1'b0, 5'd11, 1'b1});
        check("byp_data1", rsp_data, alu_func(5'b00001, 7'h3, 64'h40, 64'h4));
        @(negedge clk);
        req_valid = 1'b0;
        check("byp_issue2", {rsp_valid, x_val}, 2'b01);
        check("byp_in1_2", x_in1, 64'h900);
        @(negedge clk);
        check("byp_rsp2", {rsp_valid, rsp_illegal, rsp_rd}, {1'b1, 1'b0, 5'd12});
        check("byp_data2", rsp_data, alu_func(5'b00001, 7'h3, 64'h900, 64'h9));
        @(negedge clk);
        rsp_ready = 1'b0;
        check("byp_done", rsp_valid, 0);
`endif

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            do_txn(5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 31)), $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
